// File: rtl/arith_seq_ctrl.sv
// Multi-precision sequencer driving one shared 8-bit arithunit, LSB byte first, carry chained per byte.
// Latency: start accepted at edge 0, done pulses in the cycle after edge NBYTES+1.
// Backpressure: none; start is ignored while busy or completing, illegal op pulses err.
module arith_seq_ctrl #(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic         cin_in,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic [7:0]   au_a,
    output logic [7:0]   au_b,
    output logic         au_s1,
    output logic         au_s0,
    output logic         au_cin,
    input  logic [7:0]   au_d,
    input  logic         au_cout,
    input  logic         au_z,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         zero,
    output logic         ovf
);

    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   a_q, b_q, shadow;
    logic [1:0]     sel_q;
    logic           cin0_q, carry_q, zacc_q, ovf_sh;
    logic [IW-1:0]  idx;
    logic           last;
    logic           accept;
    logic           first_cin;
    logic           beff7;

    assign last   = (idx == LAST_IDX);
    assign accept = (state == IDLE) && start && (op != 3'b111);

    // First-byte carry: ADC/SBB take the external carry, SUB/INC force 1.
    always_comb begin
        first_cin = 1'b0;
        case (op)
            3'b001, 3'b011: first_cin = cin_in;
            3'b010, 3'b100: first_cin = 1'b1;
            default:        first_cin = 1'b0;
        endcase
    end

    // Effective sign bit of the second addend as the arithunit sees it.
    always_comb begin
        beff7 = 1'b0;
        case (sel_q)
            2'b00:   beff7 = au_b[7];
            2'b01:   beff7 = ~au_b[7];
            2'b10:   beff7 = 1'b0;
            default: beff7 = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        au_a      = 8'h00;
        au_b      = 8'h00;
        au_s1     = 1'b0;
        au_s0     = 1'b0;
        au_cin    = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                busy   = 1'b1;
                au_a   = 8'(a_q >> {idx, 3'b000});
                au_b   = 8'(b_q >> {idx, 3'b000});
                au_s1  = sel_q[1];
                au_s0  = sel_q[0];
                au_cin = (idx == '0) ? cin0_q : carry_q;
                if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            shadow  <= '0;
            sel_q   <= 2'b00;
            cin0_q  <= 1'b0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            ovf_sh  <= 1'b0;
            idx     <= '0;
            result  <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && op == 3'b111) begin
                        err <= 1'b1;
                    end else if (accept) begin
                        a_q    <= opa;
                        b_q    <= opb;
                        sel_q  <= op[2:1];
                        cin0_q <= first_cin;
                        idx    <= '0;
                        zacc_q <= 1'b1;
                    end
                end
                RUN: begin
                    shadow[8*idx +: 8] <= au_d;
                    carry_q <= au_cout;
                    zacc_q  <= zacc_q & au_z;
                    idx     <= idx + IW'(1);
                    if (last) ovf_sh <= ~(au_a[7] ^ beff7) & (au_a[7] ^ au_d[7]);
                end
                DONE: begin
                    // Architectural result and flags change only here.
                    result <= shadow;
                    cout   <= carry_q;
                    zero   <= zacc_q;
                    ovf    <= ovf_sh;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/arith_seq_ctrl.md
Name: arith_seq_ctrl

Overview:
- Multi-precision sequencer for the 8-bit arithunit datapath (ops A+B+cin, A+~B+cin, A+cin, A+FF+cin).
- Accepts two NBYTES-wide operands and an opcode, then issues one byte per clock to the external arithunit, LSB byte first.
- Chains the unit's carry between bytes and assembles the wide result, carry, zero and signed-overflow flags.
- Sits between the datapath's command source and a single shared arithunit instance.

Parameters:
NBYTES, 4, operand/result width in bytes (>=2); wide width W = 8*NBYTES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe, sampled only in IDLE
op  input  3  000 ADD, 001 ADC, 010 SUB, 011 SBB, 100 INC, 101 MOV, 110 DEC, 111 illegal
cin_in  input  1  external carry for ADC/SBB
opa  input  W  operand A, captured on accepted start
opb  input  W  operand B, captured on accepted start
au_a  output  8  byte of A driven to arithunit
au_b  output  8  byte of B driven to arithunit
au_s1  output  1  arithunit select high
au_s0  output  1  arithunit select low
au_cin  output  1  arithunit carry in
au_d  input  8  arithunit result byte (combinational from au_* outputs)
au_cout  input  1  arithunit carry out
au_z  input  1  arithunit byte-zero flag
busy  output  1  high while sequencing bytes
done  output  1  one-cycle pulse when result and flags become valid
err  output  1  one-cycle pulse on start with op=111
result  output  W  assembled result, held until next accepted start
cout  output  1  final carry out (SUB/SBB: 1 = no borrow)
zero  output  1  result == 0
ovf  output  1  signed overflow of the W-bit operation

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, err, result, cout, zero, ovf = 0; au_a, au_b = 0; au_s1, au_s0, au_cin = 0. All internal registers cleared.
- Reset mid-run aborts the operation immediately. No done pulse is produced. Operands must be re-issued.
- Opcode map, giving {s1,s0} and the first-byte cin:
  - ADD 00, cin 0; ADC 00, cin_in
  - SUB 01, cin 1; SBB 01, cin_in
  - INC 10, cin 1; MOV 10, cin 0
  - DEC 11, cin 0
- The select value is held constant for all bytes of one operation.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 with a legal op: latch opa, opb, op and the first-byte cin; clear idx and the zero accumulator (zacc=1); go to RUN.
  - start=1 with op=111: err=1 next cycle; stay IDLE; result and flags untouched.
  - au_* outputs are driven to 0 in IDLE.
- RUN (busy=1), one byte per cycle, idx = 0..NBYTES-1:
  - au_a = A[8*idx+7:8*idx], au_b = B[8*idx+7:8*idx].
  - au_cin = latched first-byte cin when idx=0, else the carry register.
  - On the clock edge: result byte idx <= au_d; carry <= au_cout; zacc <= zacc & au_z.
  - idx=NBYTES-1: also compute ovf = (a7 XNOR beff7) & (a7 XOR d7). Here beff7 is b7 for sel 00, ~b7 for 01, 0 for 10, 1 for 11. Then go to DONE.
- DONE (one cycle): done=1, busy=0. cout and zero are visible in this cycle. Return to IDLE.
- Latency: start sampled at edge 0 -> done high in the cycle after edge NBYTES+1. Next start is accepted in the IDLE cycle that follows.
- start while busy or in DONE is ignored: no queueing, no error.
- Changes to opa, opb or op after acceptance have no effect on the running operation.
- result, cout, zero and ovf update only at completion and hold until the next completion or reset. Intermediate bytes are written into an internal shadow, then copied on entry to DONE.
- Carry chain wraps only within the operation. The final carry leaves only via cout and is never fed to the next command.

Test Plan (NBYTES=4):
- ADD opa=0x00FFFFFF, opb=0x00000001 -> result 0x01000000, cout 0, zero 0, ovf 0; done exactly 5 cycles after start edge; busy high 4 cycles.
- SUB opa=opb=0x12345678 -> result 0x00000000, cout 1, zero 1, ovf 0; au_s1/au_s0=0/1 every RUN cycle, au_cin=1 on byte 0.
- ADD 0x7FFFFFFF+0x00000001 -> 0x80000000, ovf 1; then DEC opa=0x00000000 -> 0xFFFFFFFF, cout 0, zero 0, ovf 0.
- ADC opa=0xFFFFFFFF, opb=0, cin_in=1 -> result 0x00000000, cout 1, zero 1; SBB opa=0x10, opb=0x10, cin_in=0 -> 0xFFFFFFFF, cout 0.
- start with op=111 -> err pulse 1 cycle, no busy, prior result held. Then start asserted during RUN of a valid op -> ignored, single done.
- rst_n low at RUN byte 2 -> all outputs 0 asynchronously, no done. Then a new ADD 1+1 after release -> result 0x00000002.
